// File: rtl/ascon_sub_layer_ti_serial_pkg.sv
// Shared constants, FSM encoding and the unmasked Ascon S-box table for the
// three-share serial substitution layer.
package ascon_sub_layer_ti_serial_pkg;

    localparam int ASCON_COLS  = 64;
    localparam int ASCON_WORDS = 5;
    localparam int TI_SHARES   = 3;

    // Word x_k of the packed state starts at bit (4-k)*64, so bit k of a
    // column index lands at k*64 + column.
    localparam int X0_OFF = 256;
    localparam int X1_OFF = 192;
    localparam int X2_OFF = 128;
    localparam int X3_OFF = 64;
    localparam int X4_OFF = 0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [4:0] ASCON_SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic int word_off(input int w);
        return (ASCON_WORDS - 1 - w) * ASCON_COLS;
    endfunction

endpackage

// File: rtl/ascon_sbox_ti_col.sv
// Combinational 3-share TI of one Ascon S-box column. Index bit 4 is x0.
// Output share j never sees input share (j+1) mod 3.
module ascon_sbox_ti_col (
    input  logic [4:0] a0,
    input  logic [4:0] a1,
    input  logic [4:0] a2,
    output logic [4:0] y0,
    output logic [4:0] y1,
    output logic [4:0] y2
);

    // Returns word-ordered bits (b[i] = x_i) after the affine input layer.
    function automatic logic [4:0] pre_lin(input logic [4:0] a);
        logic [4:0] b;
        logic [4:0] p;
        for (int i = 0; i < 5; i++) b[i] = a[4-i];
        p    = b;
        p[0] = b[0] ^ b[4];
        p[4] = b[4] ^ b[3];
        p[2] = b[2] ^ b[1];
        return p;
    endfunction

    // x_i ^= ~x_{i+1} & x_{i+2}, with the product split over shares pa/pb.
    function automatic logic [4:0] chi_share(input logic [4:0] pl,
                                             input logic [4:0] pa,
                                             input logic [4:0] pb);
        logic [4:0] q;
        int n1;
        int n2;
        for (int i = 0; i < 5; i++) begin
            n1   = (i + 1) % 5;
            n2   = (i + 2) % 5;
            q[i] = pl[i] ^ pl[n2] ^ (pa[n1] & pa[n2]) ^ (pa[n1] & pb[n2]) ^ (pb[n1] & pa[n2]);
        end
        return q;
    endfunction

    // The output NOT on x2 is applied to share 0 only.
    function automatic logic [4:0] post_lin(input logic [4:0] q, input logic inv);
        logic [4:0] r;
        logic [4:0] y;
        r    = q;
        r[1] = q[1] ^ q[0];
        r[0] = q[0] ^ q[4];
        r[3] = q[3] ^ q[2];
        r[2] = q[2] ^ inv;
        for (int i = 0; i < 5; i++) y[4-i] = r[i];
        return y;
    endfunction

    logic [4:0] p0, p1, p2;

    always_comb begin
        p0 = pre_lin(a0);
        p1 = pre_lin(a1);
        p2 = pre_lin(a2);
        y0 = post_lin(chi_share(p0, p2, p0), 1'b1);
        y1 = post_lin(chi_share(p1, p0, p1), 1'b0);
        y2 = post_lin(chi_share(p2, p1, p2), 1'b0);
    end

endmodule

// File: rtl/ascon_sub_layer_ti_serial.sv
// Serial three-share TI Ascon substitution layer: LANES columns per cycle,
// registered per column, with optional fresh-randomness share refresh.
module ascon_sub_layer_ti_serial
    import ascon_sub_layer_ti_serial_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int REFRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [319:0]         state_in_s0,
    input  logic [319:0]         state_in_s1,
    input  logic [319:0]         state_in_s2,
    input  logic [10*LANES-1:0]  rand_in,
    output logic                 rand_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [319:0]         state_out_s0,
    output logic [319:0]         state_out_s1,
    output logic [319:0]         state_out_s2
);

    localparam int   NCHUNK = ASCON_COLS / LANES;
    localparam int   CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic RMASK  = (REFRESH != 0);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [319:0]      wk0, wk1, wk2;
    logic [319:0]      os0, os1, os2;

    logic [LANES-1:0][4:0] ci0, ci1, ci2;
    logic [LANES-1:0][4:0] co0, co1, co2;
    logic [LANES-1:0][4:0] ra, rb;
    logic [LANES-1:0][4:0] r0, r1, r2;

    // Masking rand_in with RMASK lets the no-refresh build drop it entirely.
    assign ra = rand_in[5*LANES-1:0] & {(5*LANES){RMASK}};
    assign rb = rand_in[10*LANES-1:5*LANES] & {(5*LANES){RMASK}};

    always_comb begin
        ci0 = '0;
        ci1 = '0;
        ci2 = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < ASCON_WORDS; k++) begin
                ci0[l][k] = wk0[k*ASCON_COLS + int'(cnt)*LANES + l];
                ci1[l][k] = wk1[k*ASCON_COLS + int'(cnt)*LANES + l];
                ci2[l][k] = wk2[k*ASCON_COLS + int'(cnt)*LANES + l];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ascon_sbox_ti_col u_col (
            .a0(ci0[l]),
            .a1(ci1[l]),
            .a2(ci2[l]),
            .y0(co0[l]),
            .y1(co1[l]),
            .y2(co2[l])
        );
    end

    always_comb begin
        r0 = co0 ^ ra;
        r1 = co1 ^ rb;
        r2 = co2 ^ ra ^ rb;
    end

    assign in_ready     = (state == IDLE) && !rst;
    assign state_out_s0 = os0;
    assign state_out_s1 = os1;
    assign state_out_s2 = os2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wk0       <= '0;
            wk1       <= '0;
            wk2       <= '0;
            os0       <= '0;
            os1       <= '0;
            os2       <= '0;
            out_valid <= 1'b0;
            rand_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    wk0      <= state_in_s0;
                    wk1      <= state_in_s1;
                    wk2      <= state_in_s2;
                    cnt      <= '0;
                    rand_req <= 1'b1;
                    state    <= BUSY;
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        for (int k = 0; k < ASCON_WORDS; k++) begin
                            os0[k*ASCON_COLS + int'(cnt)*LANES + l] <= r0[l][k];
                            os1[k*ASCON_COLS + int'(cnt)*LANES + l] <= r1[l][k];
                            os2[k*ASCON_COLS + int'(cnt)*LANES + l] <= r2[l][k];
                        end
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NCHUNK - 1)) begin
                        cnt       <= '0;
                        rand_req  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_sub_layer_ti_serial.sv
// Scoreboarded bench for the serial TI Ascon substitution layer across
// several LANES/REFRESH builds.
module tb_ascon_sub_layer_ti_serial;
    import ascon_sub_layer_ti_serial_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [319:0] s_in0, s_in1, s_in2;
    logic [639:0] rnd;
    logic         iv [4];
    logic         ordy [4];
    logic         ov [4];
    logic         ir [4];
    logic         rq [4];
    logic [319:0] so0 [4];
    logic [319:0] so1 [4];
    logic [319:0] so2 [4];

    int total = 0;
    int bad   = 0;
    logic [319:0] exp_q [$];

    localparam logic [319:0] ONES_MASK = {320{1'b1}};

    // dut0: LANES=8 refresh, dut1: LANES=8 no refresh, dut2: LANES=1, dut3: LANES=64
    ascon_sub_layer_ti_serial #(.LANES(8), .REFRESH(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .state_in_s0(s_in0), .state_in_s1(s_in1), .state_in_s2(s_in2),
        .rand_in(rnd[79:0]), .rand_req(rq[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .state_out_s0(so0[0]), .state_out_s1(so1[0]), .state_out_s2(so2[0]));
    ascon_sub_layer_ti_serial #(.LANES(8), .REFRESH(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .state_in_s0(s_in0), .state_in_s1(s_in1), .state_in_s2(s_in2),
        .rand_in(rnd[79:0]), .rand_req(rq[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .state_out_s0(so0[1]), .state_out_s1(so1[1]), .state_out_s2(so2[1]));
    ascon_sub_layer_ti_serial #(.LANES(1), .REFRESH(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .state_in_s0(s_in0), .state_in_s1(s_in1), .state_in_s2(s_in2),
        .rand_in(rnd[9:0]), .rand_req(rq[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .state_out_s0(so0[2]), .state_out_s1(so1[2]), .state_out_s2(so2[2]));
    ascon_sub_layer_ti_serial #(.LANES(64), .REFRESH(1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .state_in_s0(s_in0), .state_in_s1(s_in1), .state_in_s2(s_in2),
        .rand_in(rnd[639:0]), .rand_req(rq[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .state_out_s0(so0[3]), .state_out_s1(so1[3]), .state_out_s2(so2[3]));

    // Fresh randomness every cycle, changed away from the sampling edge.
    initial begin
        rnd = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 20; k++) rnd[k*32 +: 32] = $urandom();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [319:0] model(input logic [319:0] u);
        logic [319:0] r;
        logic [4:0]   idx;
        logic [4:0]   o;
        r = '0;
        for (int c = 0; c < 64; c++) begin
            idx = {u[256+c], u[192+c], u[128+c], u[64+c], u[c]};
            o   = ASCON_SBOX[idx];
            {r[256+c], r[192+c], r[128+c], r[64+c], r[c]} = o;
        end
        return r;
    endfunction

    task automatic drive_in(input int d, input logic [319:0] a, input logic [319:0] b,
                            input logic [319:0] c, input logic [319:0] e);
        @(negedge clk);
        s_in0 = a;
        s_in1 = b;
        s_in2 = c;
        iv[d] = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 iv[d] = 1'b0;
    endtask

    // Called just after the accept edge; returns edges until out_valid.
    task automatic wait_out(input int d, output int cyc, output int rqc, output bit to,
                            output logic [319:0] o0, output logic [319:0] o1,
                            output logic [319:0] o2);
        cyc = 0;
        rqc = 0;
        to  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rq[d]) rqc++;
            if (ov[d]) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        o0 = so0[d];
        o1 = so1[d];
        o2 = so2[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", ir[0]); end
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", ov[0]); end
        total++; if (rq[0] !== 1'b0) begin bad++; $display("FAIL reset_rand_req: got %0b want 0", rq[0]); end
        total++; if ((so0[0] | so1[0] | so2[0]) !== 320'h0) begin bad++; $display("FAIL reset_outputs: got nonzero share, want 0"); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %0b want 1", ir[0]); end
    endtask

    task automatic test_zero();
        logic [319:0] e, o0, o1, o2, got;
        int cyc, rqc;
        bit to;
        e = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        drive_in(1, '0, '0, '0, e);
        wait_out(1, cyc, rqc, to, o0, o1, o2);
        got = o0 ^ o1 ^ o2;
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL zero_timeout: out_valid never rose"); end
        total++; if (cyc != 8) begin bad++; $display("FAIL zero_latency: got %0d want 8", cyc); end
        total++; if (got !== e) begin bad++; $display("FAIL zero_result: got %h want %h", got, e); end
    endtask

    task automatic test_ones();
        logic [319:0] r1, r2, e, o0, o1, o2, got;
        int cyc, rqc;
        bit to;
        r1 = rand320();
        r2 = rand320();
        e  = {{64{1'b1}}, 64'h0, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}};
        drive_in(0, r1, r2, ~(r1 ^ r2), e);
        wait_out(0, cyc, rqc, to, o0, o1, o2);
        got = o0 ^ o1 ^ o2;
        e = exp_q.pop_front();
        total++; if (to || cyc != 8) begin bad++; $display("FAIL ones_latency: got %0d want 8", cyc); end
        total++; if (got !== e) begin bad++; $display("FAIL ones_result: got %h want %h", got, e); end
        total++; if (o0 === e) begin bad++; $display("FAIL ones_share0_masked: got %h equal to unmasked", o0); end
        total++; if (o1 === e) begin bad++; $display("FAIL ones_share1_masked: got %h equal to unmasked", o1); end
        total++; if (o2 === e) begin bad++; $display("FAIL ones_share2_masked: got %h equal to unmasked", o2); end
    endtask

    task automatic test_sweep();
        int dsel [3];
        int lat [3];
        logic [319:0] u, m1, m2, e, o0, o1, o2, got;
        logic [4:0] idx;
        int cyc, rqc;
        bit to;
        dsel = '{2, 0, 3};
        lat  = '{64, 8, 1};
        for (int t = 0; t < 3; t++) begin
            u = '0;
            for (int c = 0; c < 64; c++) begin
                idx = (c < 32) ? 5'(c) : 5'(63 - c);
                {u[256+c], u[192+c], u[128+c], u[64+c], u[c]} = idx;
            end
            m1 = rand320();
            m2 = rand320();
            drive_in(dsel[t], m1, m2, u ^ m1 ^ m2, model(u));
            wait_out(dsel[t], cyc, rqc, to, o0, o1, o2);
            got = o0 ^ o1 ^ o2;
            e = exp_q.pop_front();
            total++; if (to || cyc != lat[t]) begin bad++; $display("FAIL sweep_latency_%0d: got %0d want %0d", t, cyc, lat[t]); end
            total++; if (rqc != lat[t]) begin bad++; $display("FAIL sweep_rand_req_%0d: got %0d want %0d", t, rqc, lat[t]); end
            total++; if (got !== e) begin bad++; $display("FAIL sweep_result_%0d: got %h want %h", t, got, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [319:0] u, m1, m2, e, o0, o1, o2, got, p0, p1, p2;
        int cyc, rqc;
        bit to;
        ordy[0] = 1'b0;
        u  = rand320();
        m1 = rand320();
        m2 = rand320();
        drive_in(0, m1, m2, u ^ m1 ^ m2, model(u));
        wait_out(0, cyc, rqc, to, o0, o1, o2);
        got = o0 ^ o1 ^ o2;
        e = exp_q.pop_front();
        total++; if (to || got !== e) begin bad++; $display("FAIL bp_first_result: got %h want %h", got, e); end
        // Pending request raised while the block sits in DONE.
        u  = rand320();
        m1 = rand320();
        m2 = rand320();
        s_in0 = m1;
        s_in1 = m2;
        s_in2 = u ^ m1 ^ m2;
        iv[0] = 1'b1;
        exp_q.push_back(model(u));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (so0[0] !== o0 || so1[0] !== o1 || so2[0] !== o2) begin bad++; $display("FAIL bp_stable_%0d: outputs changed while held", k); end
            total++; if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin bad++; $display("FAIL bp_hold_%0d: in_ready=%0b out_valid=%0b want 0/1", k, ir[0], ov[0]); end
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin bad++; $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1/0", ir[0], ov[0]); end
        @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_out(0, cyc, rqc, to, o0, o1, o2);
        got = o0 ^ o1 ^ o2;
        e = exp_q.pop_front();
        total++; if (to || cyc != 8) begin bad++; $display("FAIL bp_pending_latency: got %0d want 8", cyc); end
        total++; if (got !== e) begin bad++; $display("FAIL bp_pending_result: got %h want %h", got, e); end
    endtask

    task automatic test_reset_mid();
        logic [319:0] u, m1, m2, e, o0, o1, o2, got;
        int cyc, rqc;
        bit to;
        u  = rand320();
        m1 = rand320();
        m2 = rand320();
        drive_in(0, m1, m2, u ^ m1 ^ m2, model(u));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        void'(exp_q.pop_front());
        total++; if (ov[0] !== 1'b0 || rq[0] !== 1'b0) begin bad++; $display("FAIL rstmid_flags: out_valid=%0b rand_req=%0b want 0/0", ov[0], rq[0]); end
        total++; if ((so0[0] | so1[0] | so2[0]) !== 320'h0) begin bad++; $display("FAIL rstmid_outputs: got nonzero share, want 0"); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin bad++; $display("FAIL rstmid_idle: in_ready=%0b out_valid=%0b want 1/0", ir[0], ov[0]); end
        u  = rand320();
        m1 = rand320();
        m2 = rand320();
        drive_in(0, m1, m2, u ^ m1 ^ m2, model(u));
        wait_out(0, cyc, rqc, to, o0, o1, o2);
        got = o0 ^ o1 ^ o2;
        e = exp_q.pop_front();
        total++; if (to || cyc != 8) begin bad++; $display("FAIL rstmid_latency: got %0d want 8", cyc); end
        total++; if (got !== e) begin bad++; $display("FAIL rstmid_result: got %h want %h", got, e); end
    endtask

    task automatic test_back_to_back_refresh();
        logic [319:0] u, m1, m2, e, o0, o1, o2, got, a0;
        int cyc, rqc;
        bit to;
        u  = rand320();
        m1 = rand320();
        m2 = rand320();
        a0 = '0;
        for (int r = 0; r < 2; r++) begin
            drive_in(0, m1, m2, u ^ m1 ^ m2, model(u));
            wait_out(0, cyc, rqc, to, o0, o1, o2);
            got = o0 ^ o1 ^ o2;
            e = exp_q.pop_front();
            total++; if (to || rqc != 8) begin bad++; $display("FAIL refresh_rand_req_%0d: got %0d want 8", r, rqc); end
            total++; if (got !== e) begin bad++; $display("FAIL refresh_result_%0d: got %h want %h", r, got, e); end
            if (r == 0) a0 = o0;
        end
        total++; if (o0 === a0) begin bad++; $display("FAIL refresh_share_diff: got %h in both runs, want different", o0); end
        total++; if ((o0 ^ o1 ^ o2 ^ ONES_MASK) === ~model(u)) begin end else begin bad++; $display("FAIL refresh_unmasked: got %h want %h", o0 ^ o1 ^ o2, model(u)); end
    endtask

    initial begin
        rst   = 1'b1;
        s_in0 = '0;
        s_in1 = '0;
        s_in2 = '0;
        for (int k = 0; k < 4; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
        end
        test_reset();
        test_zero();
        test_ones();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_back_to_back_refresh();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
